// File: rtl/iic_slave.sv
// iic_slave: I2C target on a two-wire bus. It responds to one 7-bit device
// address and serves a 2^ADDR_W-byte register file with byte/burst writes and
// random reads. SCL/SDA are oversampled on CLK, and SDA is only ever pulled low.
// Optional build macro: IIC_SLAVE_AUTOINC_EN. When it is defined, the register
// pointer steps after each written byte and after each ACKed read byte.
module iic_slave #(
    parameter logic [6:0]  DEV_ADDR = 7'b0111000,
    parameter int unsigned ADDR_W   = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              SCL,
    inout  wire               SDA,
    output logic              Wr_Sig,
    output logic [ADDR_W-1:0] Wr_Addr,
    output logic [7:0]        Wr_Data,
    input  logic [ADDR_W-1:0] Host_Addr,
    output logic [7:0]        Host_Data,
    output logic              Busy
);

    localparam int unsigned DEPTH = 32'd1 << ADDR_W;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_DEV      = 4'd1,
        S_DEV_ACK  = 4'd2,
        S_WORD     = 4'd3,
        S_WORD_ACK = 4'd4,
        S_WR       = 4'd5,
        S_WR_ACK   = 4'd6,
        S_RD       = 4'd7,
        S_RD_ACK   = 4'd8,
        S_IGNORE   = 4'd9
    } state_t;

    // Advance the register pointer. Without auto-increment, it only moves
    // when a word address is received.
    function automatic logic [ADDR_W-1:0] ptr_step(input logic [ADDR_W-1:0] p);
`ifdef IIC_SLAVE_AUTOINC_EN
        return p + ADDR_W'(1);
`else
        return p;
`endif
    endfunction

    // Bit [0] is the first sync flop, [1] is the synchronized sample and
    // [2] is the one-CLK-older sample used for edge detection.
    logic [2:0]        scl_pipe_r;
    logic [2:0]        sda_pipe_r;
    logic              scl_rise_s;
    logic              scl_fall_s;
    logic              start_s;
    logic              stop_s;
    logic              sda_bit_s;
    logic [7:0]        rx_byte_s;
    logic [7:0]        rd_byte_s;

    state_t            state_r,   state_nxt_s;
    logic [3:0]        cnt_r,     cnt_nxt_s;
    logic [7:0]        shift_r,   shift_nxt_s;
    logic [7:0]        tx_r,      tx_nxt_s;
    logic [ADDR_W-1:0] ptr_r,     ptr_nxt_s;
    logic              rw_r,      rw_nxt_s;
    logic              sda_oe_r,  sda_oe_nxt_s;
    logic              busy_r,    busy_nxt_s;
    logic              wr_sig_r,  wr_sig_nxt_s;
    logic [ADDR_W-1:0] wr_addr_r, wr_addr_nxt_s;
    logic [7:0]        wr_data_r, wr_data_nxt_s;
    logic [7:0]        reg_file_r [DEPTH];

    // Synchronize SCL/SDA and keep one delayed sample for edge detection.
    always_ff @(posedge CLK) begin
        if (RST) begin
            scl_pipe_r <= 3'b111;
            sda_pipe_r <= 3'b111;
        end else begin
            scl_pipe_r <= {scl_pipe_r[1:0], SCL};
            sda_pipe_r <= {sda_pipe_r[1:0], SDA};
        end
    end

    // START/STOP need SCL high in both samples, so an SDA change that
    // coincides with an SCL change is never taken as a bus condition.
    assign scl_rise_s = scl_pipe_r[1] & ~scl_pipe_r[2];
    assign scl_fall_s = ~scl_pipe_r[1] & scl_pipe_r[2];
    assign start_s    = scl_pipe_r[1] & scl_pipe_r[2] & ~sda_pipe_r[1] & sda_pipe_r[2];
    assign stop_s     = scl_pipe_r[1] & scl_pipe_r[2] & sda_pipe_r[1] & ~sda_pipe_r[2];
    assign sda_bit_s  = sda_pipe_r[1];
    assign rx_byte_s  = {shift_r[6:0], sda_bit_s};
    assign rd_byte_s  = reg_file_r[ptr_r];

    // Compute the next protocol state, the shift/pointer updates and the SDA drive.
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        shift_nxt_s   = shift_r;
        tx_nxt_s      = tx_r;
        ptr_nxt_s     = ptr_r;
        rw_nxt_s      = rw_r;
        sda_oe_nxt_s  = sda_oe_r;
        busy_nxt_s    = busy_r;
        wr_sig_nxt_s  = 1'b0;
        wr_addr_nxt_s = wr_addr_r;
        wr_data_nxt_s = wr_data_r;
        if (start_s) begin
            state_nxt_s  = S_DEV;
            cnt_nxt_s    = 4'd0;
            sda_oe_nxt_s = 1'b0;
            busy_nxt_s   = 1'b0;
        end else if (stop_s) begin
            state_nxt_s  = S_IDLE;
            cnt_nxt_s    = 4'd0;
            sda_oe_nxt_s = 1'b0;
            busy_nxt_s   = 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    sda_oe_nxt_s = 1'b0;
                end
                S_DEV: begin
                    if (scl_rise_s && (cnt_r < 4'd8)) begin
                        shift_nxt_s = rx_byte_s;
                        cnt_nxt_s   = cnt_r + 4'd1;
                    end else if (scl_fall_s && (cnt_r == 4'd8)) begin
                        if (shift_r[7:1] == DEV_ADDR) begin
                            state_nxt_s  = S_DEV_ACK;
                            rw_nxt_s     = shift_r[0];
                            sda_oe_nxt_s = 1'b1;
                            busy_nxt_s   = 1'b1;
                        end else begin
                            state_nxt_s  = S_IGNORE;
                            sda_oe_nxt_s = 1'b0;
                        end
                    end else begin
                        state_nxt_s = S_DEV;
                    end
                end
                S_DEV_ACK: begin
                    if (scl_fall_s) begin
                        cnt_nxt_s = 4'd0;
                        if (rw_r) begin
                            // The first read bit goes out at the fall that ends the ACK slot.
                            state_nxt_s  = S_RD;
                            tx_nxt_s     = rd_byte_s;
                            sda_oe_nxt_s = ~rd_byte_s[7];
                        end else begin
                            state_nxt_s  = S_WORD;
                            sda_oe_nxt_s = 1'b0;
                        end
                    end else begin
                        state_nxt_s = S_DEV_ACK;
                    end
                end
                S_WORD: begin
                    if (scl_rise_s && (cnt_r < 4'd8)) begin
                        shift_nxt_s = rx_byte_s;
                        cnt_nxt_s   = cnt_r + 4'd1;
                        if (cnt_r == 4'd7) begin
                            ptr_nxt_s = rx_byte_s[ADDR_W-1:0];
                        end else begin
                            ptr_nxt_s = ptr_r;
                        end
                    end else if (scl_fall_s && (cnt_r == 4'd8)) begin
                        state_nxt_s  = S_WORD_ACK;
                        sda_oe_nxt_s = 1'b1;
                    end else begin
                        state_nxt_s = S_WORD;
                    end
                end
                S_WORD_ACK, S_WR_ACK: begin
                    if (scl_fall_s) begin
                        state_nxt_s  = S_WR;
                        cnt_nxt_s    = 4'd0;
                        sda_oe_nxt_s = 1'b0;
                    end else begin
                        state_nxt_s = state_r;
                    end
                end
                S_WR: begin
                    if (scl_rise_s && (cnt_r < 4'd8)) begin
                        shift_nxt_s = rx_byte_s;
                        cnt_nxt_s   = cnt_r + 4'd1;
                        if (cnt_r == 4'd7) begin
                            // Commit on the 8th data bit, then step the pointer.
                            wr_sig_nxt_s  = 1'b1;
                            wr_addr_nxt_s = ptr_r;
                            wr_data_nxt_s = rx_byte_s;
                            ptr_nxt_s     = ptr_step(ptr_r);
                        end else begin
                            wr_sig_nxt_s = 1'b0;
                        end
                    end else if (scl_fall_s && (cnt_r == 4'd8)) begin
                        state_nxt_s  = S_WR_ACK;
                        sda_oe_nxt_s = 1'b1;
                    end else begin
                        state_nxt_s = S_WR;
                    end
                end
                S_RD: begin
                    if (scl_fall_s) begin
                        if (cnt_r == 4'd7) begin
                            // Eighth fall: hand SDA to the master for its ACK bit.
                            state_nxt_s  = S_RD_ACK;
                            cnt_nxt_s    = 4'd0;
                            sda_oe_nxt_s = 1'b0;
                        end else begin
                            tx_nxt_s     = {tx_r[6:0], 1'b0};
                            sda_oe_nxt_s = ~tx_r[6];
                            cnt_nxt_s    = cnt_r + 4'd1;
                        end
                    end else begin
                        state_nxt_s = S_RD;
                    end
                end
                S_RD_ACK: begin
                    // cnt_r flags that the master ACKed and another byte is due.
                    if (scl_rise_s) begin
                        if (!sda_bit_s) begin
                            cnt_nxt_s = 4'd1;
                            ptr_nxt_s = ptr_step(ptr_r);
                        end else begin
                            state_nxt_s  = S_IGNORE;
                            sda_oe_nxt_s = 1'b0;
                        end
                    end else if (scl_fall_s && (cnt_r == 4'd1)) begin
                        state_nxt_s  = S_RD;
                        cnt_nxt_s    = 4'd0;
                        tx_nxt_s     = rd_byte_s;
                        sda_oe_nxt_s = ~rd_byte_s[7];
                    end else begin
                        state_nxt_s = S_RD_ACK;
                    end
                end
                S_IGNORE: begin
                    sda_oe_nxt_s = 1'b0;
                end
                default: begin
                    state_nxt_s  = S_IDLE;
                    cnt_nxt_s    = 4'd0;
                    sda_oe_nxt_s = 1'b0;
                end
            endcase
        end
    end

    // Protocol state, datapath and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r   <= S_IDLE;
            cnt_r     <= 4'd0;
            shift_r   <= 8'h00;
            tx_r      <= 8'h00;
            ptr_r     <= '0;
            rw_r      <= 1'b0;
            sda_oe_r  <= 1'b0;
            busy_r    <= 1'b0;
            wr_sig_r  <= 1'b0;
            wr_addr_r <= '0;
            wr_data_r <= 8'h00;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            shift_r   <= shift_nxt_s;
            tx_r      <= tx_nxt_s;
            ptr_r     <= ptr_nxt_s;
            rw_r      <= rw_nxt_s;
            sda_oe_r  <= sda_oe_nxt_s;
            busy_r    <= busy_nxt_s;
            wr_sig_r  <= wr_sig_nxt_s;
            wr_addr_r <= wr_addr_nxt_s;
            wr_data_r <= wr_data_nxt_s;
        end
    end

    // Register file. It is written from the registered commit strobe, so the
    // host sees the new byte one CLK after Wr_Sig.
    always_ff @(posedge CLK) begin
        if (RST) begin
            reg_file_r <= '{default: 8'h00};
        end else if (wr_sig_r) begin
            reg_file_r[wr_addr_r] <= wr_data_r;
        end
    end

    assign SDA       = sda_oe_r ? 1'b0 : 1'bz;
    assign Wr_Sig    = wr_sig_r;
    assign Wr_Addr   = wr_addr_r;
    assign Wr_Data   = wr_data_r;
    assign Busy      = busy_r;
    assign Host_Data = reg_file_r[Host_Addr];

endmodule
